// File: rtl/clink_pkg.sv
// -----------------------------------------------------------------------------
// clink_pkg
// Shared definitions for the Camera Link style 7:1 link, used by both the
// transmit framer and the receive-side word unpacking.
//   - clink_state_e  : framer FSM states
//   - PX_D*_BIT      : bit position inside the 28-bit serializer word for each
//                      bit of the d0/d1/d2 taps (indexed by tap bit number)
//   - PX_*_BIT       : positions of the DVAL/FVAL/LVAL flags and the spare bit
// -----------------------------------------------------------------------------
package clink_pkg;

  localparam int unsigned PX_W  = 32'd28;
  localparam int unsigned TAP_W = 32'd8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FSETUP = 3'd1,
    ST_LINE   = 3'd2,
    ST_HBLANK = 3'd3,
    ST_VBLANK = 3'd4
  } clink_state_e;

  // Entry [i] is the serializer word bit carrying tap bit i.
  localparam logic [4:0] PX_D0_BIT [TAP_W] = '{5'd6, 5'd5, 5'd4, 5'd3,
                                               5'd2, 5'd1, 5'd27, 5'd26};
  localparam logic [4:0] PX_D1_BIT [TAP_W] = '{5'd0, 5'd13, 5'd12, 5'd11,
                                               5'd10, 5'd9, 5'd25, 5'd24};
  localparam logic [4:0] PX_D2_BIT [TAP_W] = '{5'd8, 5'd7, 5'd20, 5'd19,
                                               5'd18, 5'd17, 5'd23, 5'd22};

  localparam logic [4:0] PX_DVAL_BIT  = 5'd14;
  localparam logic [4:0] PX_FVAL_BIT  = 5'd15;
  localparam logic [4:0] PX_LVAL_BIT  = 5'd16;
  localparam logic [4:0] PX_SPARE_BIT = 5'd21;

endpackage

// File: rtl/clink_tx_pack.sv
// -----------------------------------------------------------------------------
// clink_tx_pack
// Purely combinational mapping of one beat (three 8-bit taps plus the
// DVAL/FVAL/LVAL flags) onto the 28-bit 7:1 serializer word. Tap bits are
// forced to zero whenever DVAL is low so blanking/stall words carry no data.
// Ports:
//   dval, fval, lval : link qualifiers for this beat
//   d0, d1, d2       : tap data
//   px               : 28-bit serializer word (spare bit always 0)
// -----------------------------------------------------------------------------
module clink_tx_pack
  import clink_pkg::*;
(
  input  logic        dval,
  input  logic        fval,
  input  logic        lval,
  input  logic [7:0]  d0,
  input  logic [7:0]  d1,
  input  logic [7:0]  d2,
  output logic [27:0] px
);

  // Scatter flags and (DVAL-gated) tap bits into their word positions.
  always_comb begin
    px               = '0;
    px[PX_DVAL_BIT]  = dval;
    px[PX_FVAL_BIT]  = fval;
    px[PX_LVAL_BIT]  = lval;
    px[PX_SPARE_BIT] = 1'b0;
    for (int i = 0; i < int'(TAP_W); i++) begin
      px[PX_D0_BIT[i]] = d0[i] & dval;
      px[PX_D1_BIT[i]] = d1[i] & dval;
      px[PX_D2_BIT[i]] = d2[i] & dval;
    end
  end

endmodule

// File: rtl/clink_tx_framer.sv
// -----------------------------------------------------------------------------
// clink_tx_framer
// Generates Camera Link style framing (FVAL/LVAL/DVAL) around a pixel stream
// or an internal counter pattern and emits one registered 28-bit word per
// clock for a downstream 7:1 serializer.
// Ports:
//   clk, rst_n            : pixel clock, async active-low reset
//   tx_ready              : serializer locked; dropping it aborts a frame
//   frame_start           : one-cycle request for a frame (ignored when busy)
//   cfg_continuous        : repeat frames after vertical blanking
//   cfg_test_pattern      : send beat/line/frame counters instead of pix_data
//   cfg_width/height      : beats per line / lines per frame (0 = no frame)
//   cfg_hblank/vblank     : LVAL-low / FVAL-low cycles (0 treated as 1)
//   pix_data, pix_valid   : source beat {d2,d1,d0}
//   pix_ready             : beat accepted when pix_valid && pix_ready
//   px_data               : serializer word, one cycle after the state it encodes
//   busy                  : framer not idle
//   frame_done            : pulse when the last beat of a frame went out
//   frame_abort           : pulse when a frame was cut short by tx_ready loss
// Counters must be at least 8 bits wide (CNT_W >= 8) for the test pattern.
// -----------------------------------------------------------------------------
module clink_tx_framer
  import clink_pkg::*;
#(
  parameter int CNT_W           = 16,
  parameter int TEST_PATTERN_EN = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tx_ready,
  input  logic             frame_start,
  input  logic             cfg_continuous,
  input  logic             cfg_test_pattern,
  input  logic [CNT_W-1:0] cfg_width,
  input  logic [CNT_W-1:0] cfg_height,
  input  logic [CNT_W-1:0] cfg_hblank,
  input  logic [CNT_W-1:0] cfg_vblank,
  input  logic [23:0]      pix_data,
  input  logic             pix_valid,
  output logic             pix_ready,
  output logic [27:0]      px_data,
  output logic             busy,
  output logic             frame_done,
  output logic             frame_abort
);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic             TP_BUILT = (TEST_PATTERN_EN != 0);

  clink_state_e     state_r, state_nxt_s;

  // Configuration captured at frame start; live inputs are ignored mid-frame.
  logic [CNT_W-1:0] width_r, height_r, hblank_r, vblank_r;
  logic             cont_r, tp_r;

  logic [CNT_W-1:0] blank_cnt_r, blank_nxt_s;
  logic [CNT_W-1:0] beat_cnt_r, beat_nxt_s;
  logic [CNT_W-1:0] line_cnt_r, line_nxt_s;
  logic [7:0]       frame_cnt_r, frame_nxt_s;

  logic [27:0]      px_data_r;
  logic             frame_done_r, frame_abort_r;

  logic             latch_s, done_s, abort_s;
  logic             fval_s, lval_s, dval_s, beat_acc_s;
  logic [CNT_W-1:0] hb_len_s, vb_len_s;
  logic             hb_last_s, vb_last_s, cfg_ok_s;
  logic [7:0]       d0_s, d1_s, d2_s;
  logic [27:0]      pack_px_s, px_nxt_s;

  // A zero blanking length still costs one cycle.
  assign hb_len_s  = (hblank_r == '0) ? CNT_ONE : hblank_r;
  assign vb_len_s  = (vblank_r == '0) ? CNT_ONE : vblank_r;
  assign hb_last_s = (blank_cnt_r == (hb_len_s - CNT_ONE));
  assign vb_last_s = (blank_cnt_r == (vb_len_s - CNT_ONE));
  assign cfg_ok_s  = (cfg_width != '0) && (cfg_height != '0);

  // Next-state, counter updates and link flags for the current cycle.
  always_comb begin
    state_nxt_s = state_r;
    blank_nxt_s = blank_cnt_r;
    beat_nxt_s  = beat_cnt_r;
    line_nxt_s  = line_cnt_r;
    frame_nxt_s = frame_cnt_r;
    latch_s     = 1'b0;
    done_s      = 1'b0;
    abort_s     = 1'b0;
    fval_s      = 1'b0;
    lval_s      = 1'b0;
    dval_s      = 1'b0;
    beat_acc_s  = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (frame_start && tx_ready && cfg_ok_s) begin
          state_nxt_s = ST_FSETUP;
          latch_s     = 1'b1;
          blank_nxt_s = '0;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end

      ST_FSETUP, ST_HBLANK: begin
        fval_s = 1'b1;
        if (hb_last_s) begin
          state_nxt_s = ST_LINE;
          blank_nxt_s = '0;
        end else begin
          blank_nxt_s = blank_cnt_r + CNT_ONE;
        end
      end

      ST_LINE: begin
        fval_s     = 1'b1;
        lval_s     = 1'b1;
        // Pattern mode produces a beat every cycle; otherwise wait for the source.
        beat_acc_s = tp_r | pix_valid;
        dval_s     = beat_acc_s;
        if (beat_acc_s) begin
          if (beat_cnt_r == (width_r - CNT_ONE)) begin
            beat_nxt_s  = '0;
            blank_nxt_s = '0;
            if (line_cnt_r == (height_r - CNT_ONE)) begin
              state_nxt_s = ST_VBLANK;
              line_nxt_s  = '0;
              frame_nxt_s = frame_cnt_r + 8'd1;
              done_s      = 1'b1;
            end else begin
              state_nxt_s = ST_HBLANK;
              line_nxt_s  = line_cnt_r + CNT_ONE;
            end
          end else begin
            beat_nxt_s = beat_cnt_r + CNT_ONE;
          end
        end else begin
          beat_nxt_s = beat_cnt_r;
        end
      end

      ST_VBLANK: begin
        if (vb_last_s) begin
          blank_nxt_s = '0;
          // A restart relatches the live configuration, so it must be usable.
          if (cont_r && tx_ready && cfg_ok_s) begin
            state_nxt_s = ST_FSETUP;
            latch_s     = 1'b1;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end else begin
          blank_nxt_s = blank_cnt_r + CNT_ONE;
        end
      end

      default: begin
        state_nxt_s = ST_IDLE;
        blank_nxt_s = '0;
        beat_nxt_s  = '0;
        line_nxt_s  = '0;
      end
    endcase

    // Link loss overrides everything: drop the frame and return to idle.
    if ((state_r != ST_IDLE) && !tx_ready) begin
      state_nxt_s = ST_IDLE;
      blank_nxt_s = '0;
      beat_nxt_s  = '0;
      line_nxt_s  = '0;
      frame_nxt_s = frame_cnt_r;
      latch_s     = 1'b0;
      done_s      = 1'b0;
      abort_s     = 1'b1;
    end else begin
      abort_s = 1'b0;
    end
  end

  // Tap source selection: counters in pattern mode, else the incoming beat.
  always_comb begin
    if (tp_r) begin
      d0_s = beat_cnt_r[7:0];
      d1_s = line_cnt_r[7:0];
      d2_s = frame_cnt_r;
    end else begin
      d0_s = pix_data[7:0];
      d1_s = pix_data[15:8];
      d2_s = pix_data[23:16];
    end
  end

  clink_tx_pack u_pack (
    .dval (dval_s),
    .fval (fval_s),
    .lval (lval_s),
    .d0   (d0_s),
    .d1   (d1_s),
    .d2   (d2_s),
    .px   (pack_px_s)
  );

  // An aborting cycle sends an all-zero word instead of a partial beat.
  assign px_nxt_s = abort_s ? 28'h0000000 : pack_px_s;

  // FSM state and frame counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      blank_cnt_r <= '0;
      beat_cnt_r  <= '0;
      line_cnt_r  <= '0;
      frame_cnt_r <= 8'd0;
    end else begin
      state_r     <= state_nxt_s;
      blank_cnt_r <= blank_nxt_s;
      beat_cnt_r  <= beat_nxt_s;
      line_cnt_r  <= line_nxt_s;
      frame_cnt_r <= frame_nxt_s;
    end
  end

  // Configuration capture on every entry into frame setup.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      width_r  <= '0;
      height_r <= '0;
      hblank_r <= '0;
      vblank_r <= '0;
      cont_r   <= 1'b0;
      tp_r     <= 1'b0;
    end else if (latch_s) begin
      width_r  <= cfg_width;
      height_r <= cfg_height;
      hblank_r <= cfg_hblank;
      vblank_r <= cfg_vblank;
      cont_r   <= cfg_continuous;
      tp_r     <= cfg_test_pattern & TP_BUILT;
    end else begin
      width_r  <= width_r;
      height_r <= height_r;
      hblank_r <= hblank_r;
      vblank_r <= vblank_r;
      cont_r   <= cont_r;
      tp_r     <= tp_r;
    end
  end

  // Registered serializer word and status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      px_data_r     <= 28'h0000000;
      frame_done_r  <= 1'b0;
      frame_abort_r <= 1'b0;
    end else begin
      px_data_r     <= px_nxt_s;
      frame_done_r  <= done_s;
      frame_abort_r <= abort_s;
    end
  end

  assign pix_ready   = (state_r == ST_LINE) && !tp_r;
  assign busy        = (state_r != ST_IDLE);
  assign px_data     = px_data_r;
  assign frame_done  = frame_done_r;
  assign frame_abort = frame_abort_r;

endmodule

// File: tb/tb_clink_tx_framer.sv
// -----------------------------------------------------------------------------
// tb_clink_tx_framer
// Directed bench for clink_tx_framer: a table of single-beat packing vectors
// with hand-computed serializer words, plus hand-written multi-cycle sequences
// for framing, stall, abort, reset and continuous operation.
// -----------------------------------------------------------------------------
module tb_clink_tx_framer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tx_ready;
  logic        frame_start;
  logic        cfg_continuous;
  logic        cfg_test_pattern;
  logic [15:0] cfg_width, cfg_height, cfg_hblank, cfg_vblank;
  logic [23:0] pix_data;
  logic        pix_valid;
  logic        pix_ready;
  logic [27:0] px_data;
  logic        busy, frame_done, frame_abort;

  clink_tx_framer #(.CNT_W(16), .TEST_PATTERN_EN(1)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .tx_ready         (tx_ready),
    .frame_start      (frame_start),
    .cfg_continuous   (cfg_continuous),
    .cfg_test_pattern (cfg_test_pattern),
    .cfg_width        (cfg_width),
    .cfg_height       (cfg_height),
    .cfg_hblank       (cfg_hblank),
    .cfg_vblank       (cfg_vblank),
    .pix_data         (pix_data),
    .pix_valid        (pix_valid),
    .pix_ready        (pix_ready),
    .px_data          (px_data),
    .busy             (busy),
    .frame_done       (frame_done),
    .frame_abort      (frame_abort)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Stimulus and capture state shared by the tasks below.
  logic        pv_q[$];
  logic [23:0] pd_q[$];
  logic [7:0]  d0_q[$], d1_q[$], d2_q[$];
  logic        dvl_q[$];
  logic [27:0] px_q[$];
  int          gaps_q[$];
  int fval_cnt, lval_cnt, dval_cnt, done_cnt, abort_cnt, spare_bad, zero_bad, timeout;

  typedef struct {
    logic [23:0] pix;
    logic [27:0] exp_px;
  } pack_vec_t;

  pack_vec_t vecs[8];

  // Inverse word mapping written out from the bit table.
  function automatic logic [7:0] get_d0(input logic [27:0] w);
    return {w[26], w[27], w[1], w[2], w[3], w[4], w[5], w[6]};
  endfunction
  function automatic logic [7:0] get_d1(input logic [27:0] w);
    return {w[24], w[25], w[9], w[10], w[11], w[12], w[13], w[0]};
  endfunction
  function automatic logic [7:0] get_d2(input logic [27:0] w);
    return {w[22], w[23], w[17], w[18], w[19], w[20], w[7], w[8]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic check_seq(input string name, input logic [7:0] got[$], input logic [7:0] exp[$]);
    check({name, "_len"}, 64'(got.size()), 64'(exp.size()));
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      check($sformatf("%s[%0d]", name, i), 64'(got[i]), 64'(exp[i]));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_cfg(input int w, input int h, input int hb, input int vb,
                         input logic cont, input logic tp);
    cfg_width        = 16'(w);
    cfg_height       = 16'(h);
    cfg_hblank       = 16'(hb);
    cfg_vblank       = 16'(vb);
    cfg_continuous   = cont;
    cfg_test_pattern = tp;
  endtask

  task automatic pulse_start();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  // Run until the framer goes idle, decoding px_data every cycle.
  task automatic collect(input int max_cyc, input int poke_cyc, input int stop_cont_after);
    int cyc = 0;
    logic prev_f = 1'b0;
    logic in_gap = 1'b0;
    int gap = 0;
    logic fv, lv, dv;
    d0_q.delete(); d1_q.delete(); d2_q.delete(); dvl_q.delete(); px_q.delete(); gaps_q.delete();
    fval_cnt = 0; lval_cnt = 0; dval_cnt = 0; done_cnt = 0; abort_cnt = 0;
    spare_bad = 0; zero_bad = 0; timeout = 0;
    while (1) begin
      if (cyc >= max_cyc) begin
        timeout = 1;
        break;
      end
      frame_start = (cyc == poke_cyc);
      if (cyc == poke_cyc) cfg_width = cfg_width + 16'd3;
      if (pix_ready && pv_q.size() > 0) begin
        pix_valid = pv_q.pop_front();
        if (pix_valid && pd_q.size() > 0) pix_data = pd_q.pop_front();
        else if (!pix_valid) pix_data = 24'h000000;
      end else begin
        pix_valid = 1'b0;
      end
      tick();
      cyc++;
      fv = px_data[15];
      lv = px_data[16];
      dv = px_data[14];
      if (fv) fval_cnt++;
      if (lv) begin
        lval_cnt++;
        dvl_q.push_back(dv);
      end
      if (dv) begin
        dval_cnt++;
        d0_q.push_back(get_d0(px_data));
        d1_q.push_back(get_d1(px_data));
        d2_q.push_back(get_d2(px_data));
        px_q.push_back(px_data);
      end else if ((px_data & 28'hFFE3FFF) != 28'h0000000) begin
        zero_bad++;
      end
      if (px_data[21]) spare_bad++;
      if (frame_abort) abort_cnt++;
      if (frame_done) begin
        done_cnt++;
        if (done_cnt == stop_cont_after) cfg_continuous = 1'b0;
      end
      if (!fv) begin
        if (in_gap) gap++;
        else if (prev_f) begin
          in_gap = 1'b1;
          gap = 1;
        end
      end else begin
        if (in_gap) gaps_q.push_back(gap);
        in_gap = 1'b0;
      end
      prev_f = fv;
      if (!busy) break;
    end
    frame_start = 1'b0;
    pix_valid   = 1'b0;
  endtask

  initial begin
    logic [7:0] exp_q[$];
    logic [23:0] vp;
    logic found;

    vecs[0] = '{24'hA53C81, 28'h453DF40};
    vecs[1] = '{24'h000001, 28'h001C040};
    vecs[2] = '{24'h000100, 28'h001C001};
    vecs[3] = '{24'h800000, 28'h041C000};
    vecs[4] = '{24'h000080, 28'h401C000};
    vecs[5] = '{24'hFFFFFF, 28'hFDFFFFF};
    vecs[6] = '{24'h000000, 28'h001C000};
    vecs[7] = '{24'h020000, 28'h001C080};

    rst_n = 1'b0; tx_ready = 1'b1; frame_start = 1'b0; pix_data = 24'h000000; pix_valid = 1'b0;
    set_cfg(0, 0, 0, 0, 1'b0, 1'b0);
    #12;
    check("rst_px", 64'(px_data), 64'h0);
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_ready", 64'(pix_ready), 64'h0);
    check("rst_done", 64'(frame_done), 64'h0);
    check("rst_abort", 64'(frame_abort), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Basic test-pattern frame: 4 beats x 2 lines.
    set_cfg(4, 2, 2, 3, 1'b0, 1'b1);
    pulse_start();
    check("f1_busy_early", 64'(busy), 64'h1);
    collect(100, -1, 0);
    check("f1_timeout", 64'(timeout), 64'h0);
    check("f1_fval", 64'(fval_cnt), 64'd12);
    check("f1_lval", 64'(lval_cnt), 64'd8);
    check("f1_dval", 64'(dval_cnt), 64'd8);
    check("f1_done", 64'(done_cnt), 64'd1);
    check("f1_abort", 64'(abort_cnt), 64'd0);
    check("f1_spare", 64'(spare_bad), 64'd0);
    exp_q = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd0, 8'd1, 8'd2, 8'd3};
    check_seq("f1_d0", d0_q, exp_q);
    exp_q = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd1, 8'd1, 8'd1};
    check_seq("f1_d1", d1_q, exp_q);
    tick();
    check("f1_idle", 64'(busy), 64'h0);

    // Table: one-beat frames checking the word packing.
    for (int i = 0; i < 8; i++) begin
      set_cfg(1, 1, 1, 1, 1'b0, 1'b0);
      pv_q = '{1'b1};
      pd_q = '{vecs[i].pix};
      vp = vecs[i].pix;
      pulse_start();
      collect(30, -1, 0);
      check($sformatf("pk%0d_beats", i), 64'(dval_cnt), 64'd1);
      if (px_q.size() > 0) begin
        check($sformatf("pk%0d_px", i), 64'(px_q[0]), 64'(vecs[i].exp_px));
        check($sformatf("pk%0d_d0", i), 64'(d0_q[0]), 64'(vp[7:0]));
        check($sformatf("pk%0d_d1", i), 64'(d1_q[0]), 64'(vp[15:8]));
        check($sformatf("pk%0d_d2", i), 64'(d2_q[0]), 64'(vp[23:16]));
      end else begin
        check($sformatf("pk%0d_nobeat", i), 64'(px_q.size()), 64'd1);
      end
      check($sformatf("pk%0d_spare", i), 64'(spare_bad), 64'd0);
    end

    // Source stall in the middle of a line.
    set_cfg(3, 1, 1, 1, 1'b0, 1'b0);
    pv_q = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    pd_q = '{24'h000011, 24'h000022, 24'h000033};
    pulse_start();
    collect(40, -1, 0);
    check("st_lval", 64'(lval_cnt), 64'd5);
    check("st_dval", 64'(dval_cnt), 64'd3);
    check("st_zero", 64'(zero_bad), 64'd0);
    exp_q.delete();
    foreach (dvl_q[k]) exp_q.push_back(8'(dvl_q[k]));
    begin
      logic [7:0] pat_q[$];
      pat_q = '{8'd1, 8'd0, 8'd0, 8'd1, 8'd1};
      check_seq("st_dvpat", exp_q, pat_q);
    end
    exp_q = '{8'h11, 8'h22, 8'h33};
    check_seq("st_d0", d0_q, exp_q);

    // frame_start and a width change while busy are ignored.
    set_cfg(2, 1, 1, 1, 1'b0, 1'b1);
    pulse_start();
    collect(40, 2, 0);
    check("ig_fval", 64'(fval_cnt), 64'd3);
    check("ig_lval", 64'(lval_cnt), 64'd2);
    check("ig_done", 64'(done_cnt), 64'd1);
    tick();
    tick();
    check("ig_idle", 64'(busy), 64'h0);

    // Link loss during the second line.
    set_cfg(4, 2, 1, 1, 1'b0, 1'b1);
    pulse_start();
    found = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (px_data[14] && get_d1(px_data) == 8'd1) begin
        found = 1'b1;
        break;
      end
    end
    check("ab_reach", 64'(found), 64'h1);
    tx_ready = 1'b0;
    tick();
    check("ab_pulse", 64'(frame_abort), 64'h1);
    check("ab_px", 64'(px_data), 64'h0);
    check("ab_busy", 64'(busy), 64'h0);
    tx_ready = 1'b1;
    tick();
    check("ab_pulse_end", 64'(frame_abort), 64'h0);
    check("ab_stay_idle", 64'(busy), 64'h0);

    // Asynchronous reset in the middle of a line.
    set_cfg(4, 2, 1, 1, 1'b0, 1'b0);
    pv_q.delete();
    pix_valid = 1'b0;
    pulse_start();
    found = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (px_data[16]) begin
        found = 1'b1;
        break;
      end
    end
    check("rs_reach", 64'(found), 64'h1);
    check("rs_ready_pre", 64'(pix_ready), 64'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rs_px", 64'(px_data), 64'h0);
    check("rs_busy", 64'(busy), 64'h0);
    check("rs_ready", 64'(pix_ready), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Zero-size and link-down requests do nothing.
    set_cfg(0, 2, 1, 1, 1'b0, 1'b1);
    pulse_start();
    check("zw_busy", 64'(busy), 64'h0);
    tick();
    check("zw_px", 64'(px_data), 64'h0);
    set_cfg(3, 0, 1, 1, 1'b0, 1'b1);
    pulse_start();
    check("zh_busy", 64'(busy), 64'h0);
    set_cfg(3, 1, 1, 1, 1'b0, 1'b1);
    tx_ready = 1'b0;
    pulse_start();
    check("nr_busy", 64'(busy), 64'h0);
    tx_ready = 1'b1;
    tick();

    // Three back-to-back frames; frame counter starts at 0 after reset.
    set_cfg(2, 1, 1, 3, 1'b1, 1'b1);
    pulse_start();
    collect(200, -1, 2);
    check("ct_timeout", 64'(timeout), 64'h0);
    check("ct_done", 64'(done_cnt), 64'd3);
    check("ct_fval", 64'(fval_cnt), 64'd9);
    check("ct_ngaps", 64'(gaps_q.size()), 64'd2);
    foreach (gaps_q[k]) check($sformatf("ct_gap%0d", k), 64'(gaps_q[k]), 64'd3);
    exp_q = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd2, 8'd2};
    check_seq("ct_d2", d2_q, exp_q);
    exp_q = '{8'd0, 8'd1, 8'd0, 8'd1, 8'd0, 8'd1};
    check_seq("ct_d0", d0_q, exp_q);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clink_tx_framer.md
CLINK_TX_FRAMER -- requirements
Module: clink_tx_framer

Interface
REQ-001 SHALL have parameter CNT_W, default 16, meaning width of all geometry/blanking config fields and counters.
REQ-002 SHALL have parameter TEST_PATTERN_EN, default 1, meaning internal test-pattern source is built in.
REQ-003 clk  input  1  single clock for all logic, serializer parallel (pixel) clock.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 tx_ready  input  1  downstream 7:1 serializer locked and aligned.
REQ-006 frame_start  input  1  single-cycle request to send one frame.
REQ-007 cfg_continuous  input  1  when 1, frames repeat back-to-back after vblank.
REQ-008 cfg_test_pattern  input  1  when 1, drive internal pattern instead of pix_data.
REQ-009 cfg_width, cfg_height, cfg_hblank, cfg_vblank  input  CNT_W each  beats per line, lines per frame, LVAL-low cycles, FVAL-low cycles.
REQ-010 pix_data  input  24  {d2,d1,d0} taps of one beat.
REQ-011 pix_valid  input  1  pix_data valid.
REQ-012 pix_ready  output  1  beat accepted when pix_valid && pix_ready.
REQ-013 px_data  output  28  serializer word, registered.
REQ-014 busy  output  1  state != IDLE.
REQ-015 frame_done, frame_abort  output  1 each  single-cycle status pulses.

Function
REQ-016 States: IDLE, FSETUP, LINE, HBLANK, VBLANK.
REQ-017 IDLE -> FSETUP when frame_start && tx_ready && cfg_width!=0 && cfg_height!=0; all cfg_* latched on this cycle; cfg changes afterwards ignored until next latch.
REQ-018 FSETUP: FVAL=1, LVAL=0, DVAL=0 for max(cfg_hblank,1) cycles, then LINE.
REQ-019 LINE: FVAL=1, LVAL=1; pix_ready=1 only in LINE with cfg_test_pattern=0; DVAL=1 on accepted beat, else DVAL=0 with LVAL held high and counters frozen (stall).
REQ-020 Beat counter increments per accepted beat (every LINE cycle in test-pattern mode); at beat cfg_width-1: last line -> VBLANK, else HBLANK; line counter increments, wraps to 0 at frame end.
REQ-021 HBLANK: FVAL=1, LVAL=0, DVAL=0 for max(cfg_hblank,1) cycles, then LINE.
REQ-022 VBLANK: all flags 0 for max(cfg_vblank,1) cycles; then FSETUP (relatching cfg) if cfg_continuous && tx_ready, else IDLE.
REQ-023 frame_done pulses 1 cycle on LINE->VBLANK transition.
REQ-024 tx_ready low in any non-IDLE state -> IDLE next cycle, px_data=0, frame_abort pulses 1 cycle.
REQ-025 frame_start while busy ignored; in IDLE with cfg_width or cfg_height 0 ignored.
REQ-026 Test pattern: d0=beat count[7:0], d1=line count[7:0], d2=frame count[7:0] (frame count increments at frame_done, wraps at 255).
REQ-027 Latency: px_data registered exactly 1 cycle after the state/beat it encodes; pix_ready is combinational from state.
REQ-028 Packing (px_data bit <- signal): 0<-d1[0], 1<-d0[5], 2<-d0[4], 3<-d0[3], 4<-d0[2], 5<-d0[1], 6<-d0[0], 7<-d2[1], 8<-d2[0], 9<-d1[5], 10<-d1[4], 11<-d1[3], 12<-d1[2], 13<-d1[1], 14<-DVAL, 15<-FVAL, 16<-LVAL, 17<-d2[5], 18<-d2[4], 19<-d2[3], 20<-d2[2], 21<-0 (spare), 22<-d2[7], 23<-d2[6], 24<-d1[7], 25<-d1[6], 26<-d0[7], 27<-d0[6].
REQ-029 d0/d1/d2 SHALL be 0 whenever DVAL=0.

Reset
REQ-030 On rst_n low: state IDLE, all counters 0, px_data=0, pix_ready=0, busy=0, frame_done=0, frame_abort=0, latched cfg 0; reset asserted mid-frame takes effect immediately with no partial word.

Structure
REQ-031 Package clink_pkg SHALL hold the state enum, the 28-entry bit-index constants of REQ-028, and DVAL/FVAL/LVAL/spare index constants, shared with the receive-side mapping.
REQ-032 One sub-module clink_tx_pack SHALL implement REQ-028/REQ-029 combinationally; framer holds FSM, counters, output register.

Verification
REQ-033 width=4, height=2, hblank=2, vblank=3, test pattern, one frame_start -> FVAL high 2+4+2+4=12 cycles, LVAL high 2x4 cycles, d0 0,1,2,3 per line, frame_done once, then IDLE.
REQ-034 width=3, pix_valid low on 2nd beat for 2 cycles -> LVAL stays high 5 cycles, DVAL pattern 1,0,0,1,1, 3 beats accepted.
REQ-035 tx_ready dropped during line 1 -> frame_abort 1 cycle, px_data=0 next cycle, busy=0.
REQ-036 cfg_continuous=1, 3 frames -> vblank gaps exactly cfg_vblank cycles, d2 in test pattern 0,1,2.
REQ-037 pix_data=24'hA5_3C_81, one beat -> px_data bits decode via inverse mapping to d0=81, d1=3C, d2=A5, bit21=0.
REQ-038 rst_n low mid-LINE and cfg_width=0 frame_start -> all outputs 0 immediately; zero-width request leaves busy=0.
